// File: rtl/regfile_op_sequencer.sv
`timescale 1ns/1ps
// Four-phase (IDLE/READ/EXEC/WRITE) ALU sequencer driving a 4x16 dual-read/dual-write register file.
// Optional SWAP instruction on opcode 111 is enabled by defining SWAP_EN; otherwise 111 is a NOP.
module regfile_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INS_VALID,
  output logic              INS_READY,
  input  logic [2:0]        INS_OP,
  input  logic [ADDR_W-1:0] INS_RD,
  input  logic [ADDR_W-1:0] INS_RS,
  input  logic [ADDR_W-1:0] INS_RT,
  output logic [ADDR_W-1:0] RAA,
  output logic              REA,
  input  logic [DATA_W-1:0] RDA,
  output logic [ADDR_W-1:0] RAB,
  output logic              REB,
  input  logic [DATA_W-1:0] RDB,
  output logic [ADDR_W-1:0] WA1,
  output logic [DATA_W-1:0] WD1,
  output logic              WE1,
  output logic [ADDR_W-1:0] WA2,
  output logic [DATA_W-1:0] WD2,
  output logic              WE2,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO,
  output logic              CARRY,
  output logic [1:0]        dbg_state
);

  // Instruction handshake: an instruction transfers on a rising CLK edge where
  // INS_VALID and INS_READY are both high; the source holds its fields until then.

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   res_q;
  logic                carry_q;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                alu_wr;
  logic [DATA_W:0]     alu_sum;

  assign dbg_state = state;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_wr    = 1'b1;
    alu_sum   = '0;
    case (op_q)
      OP_ADD: begin
        alu_sum   = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_carry = alu_sum[DATA_W];
      end
      OP_SUB: begin
        alu_res   = op_a - op_b;
        alu_carry = (op_a < op_b);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_MOV: alu_res = op_a;
      OP_SHL: begin
        alu_res   = {op_a[DATA_W-2:0], 1'b0};
        alu_carry = op_a[DATA_W-1];
      end
      default: begin
`ifdef SWAP_EN
        alu_res = op_b;
`else
        alu_res = op_a;
        alu_wr  = 1'b0;
`endif
      end
    endcase
  end

  // RAA/RAB stay at the accepted RS/RT after READ, so they double as the latched source fields.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      INS_READY <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      RAA       <= '0;
      REA       <= 1'b0;
      RAB       <= '0;
      REB       <= 1'b0;
      WA1       <= '0;
      WD1       <= '0;
      WE1       <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= '0;
      ZERO      <= 1'b0;
      CARRY     <= 1'b0;
`ifdef SWAP_EN
      WA2       <= '0;
      WD2       <= '0;
      WE2       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (INS_VALID && INS_READY) begin
            op_q      <= INS_OP;
            rd_q      <= INS_RD;
            RAA       <= INS_RS;
            RAB       <= INS_RT;
            REA       <= 1'b1;
            REB       <= 1'b1;
            INS_READY <= 1'b0;
            state     <= READ;
          end else begin
            INS_READY <= 1'b1;
          end
        end
        READ: begin
          op_a  <= RDA;
          op_b  <= RDB;
          REA   <= 1'b0;
          REB   <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_res;
          carry_q <= alu_carry;
          DONE    <= 1'b1;
          WE1     <= alu_wr;
          if (alu_wr) begin
            WA1 <= rd_q;
            WD1 <= alu_res;
          end
`ifdef SWAP_EN
          if (op_q == 3'b111) begin
            WA1 <= RAA;
            WA2 <= RAB;
            WD2 <= op_a;
            WE2 <= (RAA != RAB);
          end
`endif
          state <= WRITE;
        end
        WRITE: begin
          WE1       <= 1'b0;
          WA1       <= '0;
          WD1       <= '0;
          DONE      <= 1'b0;
          RESULT    <= res_q;
          ZERO      <= (res_q == '0);
          CARRY     <= carry_q;
          INS_READY <= 1'b1;
`ifdef SWAP_EN
          WE2       <= 1'b0;
          WA2       <= '0;
          WD2       <= '0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SWAP_EN
  assign WA2 = '0;
  assign WD2 = '0;
  assign WE2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
`timescale 1ns/1ps
// Bench for regfile_op_sequencer: owns a 4x16 register file, drives instructions,
// and scoreboards write-back and flags against an arithmetic reference model.
module tb_regfile_op_sequencer;
  localparam int DW = 16;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          INS_VALID = 1'b0;
  logic          INS_READY;
  logic [2:0]    INS_OP = '0;
  logic [AW-1:0] INS_RD = '0, INS_RS = '0, INS_RT = '0;
  logic [AW-1:0] RAA, RAB, WA1, WA2;
  logic          REA, REB, WE1, WE2, DONE, ZERO, CARRY;
  logic [DW-1:0] RDA, RDB, WD1, WD2, RESULT;
  logic [1:0]    dbg_state;

  regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .INS_VALID(INS_VALID), .INS_READY(INS_READY),
    .INS_OP(INS_OP), .INS_RD(INS_RD), .INS_RS(INS_RS), .INS_RT(INS_RT),
    .RAA(RAA), .REA(REA), .RDA(RDA), .RAB(RAB), .REB(REB), .RDB(RDB),
    .WA1(WA1), .WD1(WD1), .WE1(WE1), .WA2(WA2), .WD2(WD2), .WE2(WE2),
    .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // register file: combinational read, write on posedge, bench preload port
  logic [DW-1:0] rf [4];
  logic [DW-1:0] ref_rf [4];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign RDA = REA ? rf[RAA] : 'z;
  assign RDB = REB ? rf[RAB] : 'z;
  always @(posedge CLK) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    if (WE1) rf[WA1] <= WD1;
    if (WE2) rf[WA2] <= WD2;
  end

  typedef struct packed {
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          we2;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wd2;
    logic [DW-1:0] result;
    logic          zero;
    logic          carry;
    int            done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_e;
  bit   pend = 1'b0;
  int   n_cmp = 0, n_bad = 0, n_acc = 0, n_done = 0, last_acc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: one instruction's architectural effect
  function automatic exp_t model(input logic [2:0] op, input logic [AW-1:0] rd, rs, rt);
    exp_t e;
    logic [DW-1:0] a, b, r;
    logic [DW:0]   s;
    logic          c;
    a = ref_rf[rs];
    b = ref_rf[rt];
    c = 1'b0;
    e = '0;
    case (op)
      3'd0: begin s = a + b; r = s[DW-1:0]; c = s[DW]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a;
      3'd6: begin r = a << 1; c = (a >= 16'h8000); end
      default: r = '0;
    endcase
    if (op != 3'd7) begin
      e.we1 = 1'b1; e.wa1 = rd; e.wd1 = r;
    end else begin
`ifdef SWAP_EN
      r = b;
      e.we1 = 1'b1; e.wa1 = rs; e.wd1 = b;
      e.we2 = (rs != rt); e.wa2 = rt; e.wd2 = a;
`else
      r = a;
`endif
    end
    e.result = r;
    e.zero   = (r == 0);
    e.carry  = c;
    return e;
  endfunction

  // driver: called at a negedge, returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rs, rt, input bit held);
    exp_t e;
    int   budget = 0;
    INS_VALID = 1'b1; INS_OP = op; INS_RD = rd; INS_RS = rs; INS_RT = rt;
    while (!INS_READY && budget < 20) begin @(negedge CLK); budget++; end
    if (!INS_READY) begin
      check("accept_timeout", 32'(budget), 32'd0);
      INS_VALID = 1'b0;
      return;
    end
    if (held) check("accept_gap", 32'(cyc - last_acc), 32'd4);
    last_acc = cyc;
    e = model(op, rd, rs, rt);
    e.done_cyc = cyc + 3;
    if (e.we1) ref_rf[e.wa1] = e.wd1;
    if (e.we2) ref_rf[e.wa2] = e.wd2;
    exp_q.push_back(e);
    n_acc++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_reg(input int i, input logic [DW-1:0] v);
    pre_we = 1'b1; pre_addr = AW'(i); pre_data = v; ref_rf[i] = v;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    INS_VALID = 1'b0;
    while ((exp_q.size() != 0 || pend) && b < 100) begin @(negedge CLK); b++; end
    if (b >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s_r%0d", tag, i), 32'(rf[i]), 32'(ref_rf[i]));
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (!RST) begin
      if (pend) begin
        check("result", 32'(RESULT), 32'(pend_e.result));
        check("zero", 32'(ZERO), 32'(pend_e.zero));
        check("carry", 32'(CARRY), 32'(pend_e.carry));
        pend = 1'b0;
      end
      if (DONE) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          pend_e = exp_q.pop_front();
          pend = 1'b1;
          check("done_latency", 32'(cyc), 32'(pend_e.done_cyc));
          check("we1", 32'(WE1), 32'(pend_e.we1));
          if (pend_e.we1) begin
            check("wa1", 32'(WA1), 32'(pend_e.wa1));
            check("wd1", 32'(WD1), 32'(pend_e.wd1));
          end
          check("we2", 32'(WE2), 32'(pend_e.we2));
          if (pend_e.we2) begin
            check("wa2", 32'(WA2), 32'(pend_e.wa2));
            check("wd2", 32'(WD2), 32'(pend_e.wd2));
          end
        end
      end else begin
        check("write_without_done", 32'({WE1, WE2}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] save_rf [4];
    bit held;
    for (int i = 0; i < 4; i++) begin rf[i] = '0; ref_rf[i] = '0; end
    repeat (2) @(negedge CLK);
    check("rst_ready", 32'(INS_READY), 32'd0);
    check("rst_outputs", 32'({WE1, WE2, DONE, REA, REB, ZERO, CARRY}), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // ADD 3+4 -> R0
    set_reg(1, 16'h0003); set_reg(2, 16'h0004);
    issue(3'd0, 2'd0, 2'd1, 2'd2, 1'b0);
    wait_idle();
    check("add_r0", 32'(rf[0]), 32'h0007);

    // reset mid-READ aborts the instruction
    save_rf = ref_rf;
    issue(3'd0, 2'd3, 2'd1, 2'd2, 1'b0);
    INS_VALID = 1'b0;
    RST = 1'b1;
    #1;
    check("abort_ready", 32'(INS_READY), 32'd0);
    check("abort_we_done", 32'({WE1, WE2, DONE, REA}), 32'd0);
    check("abort_result", 32'(RESULT), 32'd0);
    exp_q.delete();
    pend = 1'b0;
    n_acc--;
    ref_rf = save_rf;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_ready", 32'(INS_READY), 32'd1);
    check_rf("abort");

    // carry-out / zero and borrow
    set_reg(1, 16'hFFFF); set_reg(2, 16'h0001);
    issue(3'd0, 2'd3, 2'd1, 2'd2, 1'b0);
    issue(3'd1, 2'd2, 2'd2, 2'd1, 1'b1);
    wait_idle();
    check("add_wrap_r3", 32'(rf[3]), 32'h0000);
    check("sub_borrow_r2", 32'(rf[2]), 32'h0002);

    // SHL1 in place then MOV sees the prior write
    set_reg(1, 16'h8001);
    issue(3'd6, 2'd1, 2'd1, 2'd0, 1'b0);
    issue(3'd5, 2'd0, 2'd1, 2'd2, 1'b1);
    wait_idle();
    check("shl_r1", 32'(rf[1]), 32'h0002);
    check("mov_r0", 32'(rf[0]), 32'h0002);

    // opcode 111: SWAP (or NOP), distinct and equal sources
    set_reg(0, 16'hAAAA); set_reg(1, 16'h5555); set_reg(2, 16'h1234);
    issue(3'd7, 2'd3, 2'd0, 2'd1, 1'b0);
    issue(3'd7, 2'd3, 2'd2, 2'd2, 1'b1);
    wait_idle();
    check_rf("op7");

    // INS_VALID held high: accept every 4th cycle
    for (int i = 0; i < 8; i++)
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), i != 0);
    wait_idle();
    check_rf("burst");

    // random traffic with random gaps
    for (int i = 0; i < 4; i++) set_reg(i, 16'($urandom));
    held = 1'b0;
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), held);
      held = 1'($urandom_range(0, 1));
      if (!held) begin
        INS_VALID = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
    end
    wait_idle();
    check_rf("random");
    check("done_count", 32'(n_done), 32'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
